tone_period_decoder: RTL and testbench
======================================

// Module: tone_period_decoder
// PURPOSE
//  Receive-side counterpart of the square-wave tone oscillator. Measures the
//  spacing between successive edges of an incoming tone. Reports the equivalent
//  oscillator counter_top value and a coarse code recovered from it. Flags lock
//  on a steady tone and silence on a dead input. Sits between an external pin
//  and LED/debug logic.
// PARAMETERS
//  WIDTH       17  width of edge-spacing counter and top_out
//  CODE_SHIFT  9   right-shift from top value to code (must be >= 1)
//  CODE_W      6   width of recovered code
//  TOL         2   max |difference| between consecutive measurements that counts as a match
//  LOCK_COUNT  4   consecutive matches required to assert locked
// PORTS
//  clk        in   1       system clock; sole clock domain
//  rst        in   1       synchronous reset, active-low
//  tone_in    in   1       asynchronous square-wave input
//  top_out    out  WIDTH   last measured spacing minus 1 (= oscillator counter_top)
//  top_valid  out  1       one-cycle strobe; top_out updated this cycle
//  code       out  CODE_W  rounded top_out >> CODE_SHIFT, saturating
//  locked     out  1       tone stable within TOL for LOCK_COUNT matches
//  silent     out  1       no edge for 2^WIDTH-1 cycles, or no edge since reset
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): sync flops, cnt, top_out, code, match_cnt = 0;
//    locked=0; top_valid=0; silent=1; armed=0. Reset mid-measurement discards it.
//  - Synchroniser: tone_in -> s1 -> s2 -> s3. edge = s2 ^ s3; both polarities count.
//  - cnt: cleared on an edge cycle, else +1 per cycle, saturating at all-ones.
//    Edges N cycles apart leave cnt = N-1 on the second edge.
//  - States:
//    IDLE: entered at reset or on timeout. First edge -> ARMED; nothing reported.
//    ARMED: on an edge with cnt < all-ones: top_out<=cnt; top_valid=1 the
//    following cycle. Stay in ARMED.
//  - Timeout: cnt reaching all-ones in any state -> silent=1, locked=0,
//    match_cnt=0, state=IDLE; top_out and code hold.
//  - Edge while cnt==all-ones: the saturated count is never reported. The edge
//    acts as an arming edge (IDLE -> ARMED, silent=0 next cycle).
//  - silent clears on the cycle after any arming edge.
//  - Lock tracking on each report, comparing new value m with the previous
//    report p:
//    no previous report since arming: match_cnt=0.
//    |m-p| <= TOL: match_cnt <= min(match_cnt+1, LOCK_COUNT).
//    else: match_cnt=0, locked=0.
//    locked=1 when match_cnt==LOCK_COUNT, registered alongside top_valid.
//  - code: updates only on a report where locked is (becoming) 1; otherwise holds.
//    code = min((m + 2^(CODE_SHIFT-1)) >> CODE_SHIFT, 2^CODE_W-1).
//    Compute in WIDTH+1 bits; no wrap.
//  - Latency: tone_in edge -> top_valid is 4 clk cycles.
//  - Minimum spacing N=1 (edge every cycle) reports top_out=0.
// TESTING
//  1. Half-period 0x1201 clk, 6 edges -> 5 top_valid pulses, top_out=0x1200,
//     locked=1 after 5th pulse, code=9, silent=0.
//  2. Locked tone, then spacings alternate 0x1200/0x1202 -> stays locked;
//     then spacing 0x1205 -> top_valid pulses, locked=0, code holds 9.
//  3. tone_in held after lock -> silent=1 and locked=0 exactly 2^17-1 cycles
//     after the last edge; top_out holds.
//  4. tone_in toggling every clk -> top_out=0 each report, locked after 5
//     reports, code=0.
//  5. Lock to top 0x1FF00 -> code=63 (saturated). Lock to top 0x0FF -> code=0.
//     Lock to top 0x100 -> code=1.
//  6. rst low 1 cycle mid-period -> all outputs at reset values; next edge
//     only arms, with no top_valid.

Source files
------------

// File: rtl/tone_period_decoder.sv
// Tone period decoder: measures the spacing between edges of an asynchronous square
// wave and recovers the oscillator top value, a coarse code, and lock/silence flags.
module tone_period_decoder #(
  parameter int WIDTH      = 17,
  parameter int CODE_SHIFT = 9,
  parameter int CODE_W     = 6,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tone_in,
  output logic [WIDTH-1:0]  top_out,
  output logic              top_valid,
  output logic [CODE_W-1:0] code,
  output logic              locked,
  output logic              silent
);

  localparam int STAGES = 1;
  localparam int MW     = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] NEAR_TOP = ALL_ONES - 1'b1;
  localparam logic [WIDTH-1:0] TOL_W    = WIDTH'(TOL);
  localparam logic [MW-1:0]    LOCK_N   = MW'(LOCK_COUNT);
  localparam logic [WIDTH:0]   HALF     = (WIDTH+1)'(1) << (CODE_SHIFT - 1);
  localparam logic [WIDTH:0]   CODE_MAX = (WIDTH+1)'((1 << CODE_W) - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              tone_edge;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  meas;
  logic [WIDTH-1:0]  prev;
  logic              have_prev;
  logic [MW-1:0]     match_cnt;
  logic [STAGES:0]   vld_pipe;

  logic [WIDTH-1:0]  diff;
  logic [MW-1:0]     match_nxt;
  logic [WIDTH:0]    rounded;
  logic [WIDTH:0]    shifted;
  logic [CODE_W-1:0] code_calc;

  assign tone_edge = s2 ^ s3;
  assign top_valid = vld_pipe[STAGES];

  // Second stage: lock tracking against the previous report, and code recovery
  always_comb begin
    diff      = (meas >= prev) ? (meas - prev) : (prev - meas);
    match_nxt = '0;
    if (have_prev && diff <= TOL_W)
      match_nxt = (match_cnt == LOCK_N) ? LOCK_N : match_cnt + 1'b1;
    rounded   = {1'b0, meas} + HALF;
    shifted   = rounded >> CODE_SHIFT;
    code_calc = (shifted > CODE_MAX) ? '1 : shifted[CODE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      meas      <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      match_cnt <= '0;
      vld_pipe  <= '0;
      top_out   <= '0;
      code      <= '0;
      locked    <= 1'b0;
      silent    <= 1'b1;
      state     <= IDLE;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
      cnt      <= tone_edge ? '0 : ((cnt == ALL_ONES) ? cnt : cnt + 1'b1);
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};

      if (vld_pipe[0]) begin
        top_out   <= meas;
        prev      <= meas;
        have_prev <= 1'b1;
        match_cnt <= match_nxt;
        locked    <= (match_nxt == LOCK_N);
        if (match_nxt == LOCK_N) code <= code_calc;
      end

      if (tone_edge) begin
        // A saturated count is meaningless, so that edge only re-arms
        if (state == ARMED && cnt != ALL_ONES) begin
          meas        <= cnt;
          vld_pipe[0] <= 1'b1;
        end else begin
          state     <= ARMED;
          silent    <= 1'b0;
          have_prev <= 1'b0;
          match_cnt <= '0;
        end
      end else if (cnt == NEAR_TOP) begin
        state     <= IDLE;
        silent    <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed and randomized tone sequences checked against a spacing-based reference model.
module tb_tone_period_decoder;
  localparam int W = 12, CS = 4, CW = 6, TOL = 2, LC = 4;
  localparam int ALL = (1 << W) - 1;

  logic clk = 1'b0, rst = 1'b0, tone_in = 1'b0;
  logic [W-1:0]  top_out;
  logic          top_valid;
  logic [CW-1:0] code;
  logic          locked, silent;

  always #5 clk = ~clk;

  tone_period_decoder #(.WIDTH(W), .CODE_SHIFT(CS), .CODE_W(CW), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in), .top_out(top_out), .top_valid(top_valid),
    .code(code), .locked(locked), .silent(silent)
  );

  typedef struct {int top; int lk; int cd;} rep_t;
  rep_t exp_q[$];
  rep_t obs_q[$];
  int n_checks = 0, n_pass = 0, since = 0;
  int m_armed, m_have, m_prev, m_match, m_locked, m_code;

  always @(negedge clk)
    if (rst && top_valid) obs_q.push_back('{int'(top_out), int'(locked), int'(code)});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  task automatic model_reset();
    m_armed = 0; m_have = 0; m_prev = 0; m_match = 0; m_locked = 0; m_code = 0;
  endtask

  task automatic model_timeout();
    m_armed = 0; m_match = 0; m_locked = 0;
  endtask

  // One edge arriving 'sp' cycles after the previous one
  task automatic model_edge(input int sp);
    int m, d, c;
    if (!m_armed) begin
      m_armed = 1; m_have = 0; m_match = 0;
    end else begin
      m = sp - 1;
      d = (m > m_prev) ? m - m_prev : m_prev - m;
      if (!m_have) m_match = 0;
      else if (d <= TOL) m_match = (m_match + 1 > LC) ? LC : m_match + 1;
      else m_match = 0;
      m_locked = (m_match == LC);
      if (m_locked) begin
        c = (m + (1 << (CS - 1))) >> CS;
        m_code = (c > (1 << CW) - 1) ? (1 << CW) - 1 : c;
      end
      m_prev = m; m_have = 1;
      exp_q.push_back('{m, m_locked, m_code});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    since += n;
  endtask

  task automatic drive_edge(input int g);
    int sp;
    if (g > since) tick(g - since);
    sp = since;
    tone_in = ~tone_in;
    since = 0;
    model_edge(sp);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    tone_in = 1'b0;
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    since = 0;
    model_reset();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_top"}, top_out, 0);
    check({tag, "_valid"}, top_valid, 0);
    check({tag, "_code"}, code, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_silent"}, silent, 1);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_top%0d", tag, i), obs_q[i].top, exp_q[i].top);
      check($sformatf("%s_lock%0d", tag, i), obs_q[i].lk, exp_q[i].lk);
      check($sformatf("%s_code%0d", tag, i), obs_q[i].cd, exp_q[i].cd);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_reset("rst");

    // Steady tone, spacing 0x121 -> top 0x120; also the 4-cycle latency
    drive_edge(10);
    repeat (4) drive_edge(32'h121);
    drive_edge(32'h121);
    tick(3);
    check("lat3", top_valid, 0);
    tick(1);
    check("lat4", top_valid, 1);
    tick(10);
    compare("t1");
    check("t1_locked", locked, 1);
    check("t1_code", code, 18);
    check("t1_silent", silent, 0);

    // Jitter within tolerance keeps lock; a jump of 3 drops it
    for (int i = 0; i < 4; i++) begin
      drive_edge(32'h121);
      drive_edge(32'h123);
    end
    drive_edge(32'h126);
    tick(10);
    compare("t2");
    check("t2_locked", locked, 0);
    check("t2_code", code, 18);

    // Relock, then hold the input until timeout
    repeat (4) drive_edge(32'h126);
    tick(ALL + 2);
    check("to_silent_before", silent, 0);
    check("to_locked_before", locked, 1);
    tick(1);
    check("to_silent", silent, 1);
    check("to_locked", locked, 0);
    check("to_top_hold", top_out, 32'h125);
    check("to_code_hold", code, 18);
    model_timeout();
    compare("relock");
    drive_edge(since + 5);
    tick(10);
    check("rearm_silent", silent, 0);
    compare("rearm");

    // Edge every cycle
    do_reset(3);
    drive_edge(3);
    repeat (6) drive_edge(1);
    tick(10);
    compare("t4");
    check("t4_locked", locked, 1);
    check("t4_code", code, 0);

    // Code saturation and rounding boundaries
    do_reset(3);
    drive_edge(3);
    repeat (5) drive_edge(32'hFF1);
    tick(10);
    compare("sat");
    check("sat_code", code, 63);
    repeat (5) drive_edge(8);
    tick(10);
    compare("low");
    check("low_code", code, 0);
    repeat (2) drive_edge(9);
    tick(10);
    compare("rnd");
    check("rnd_code", code, 1);

    // Random tones with small jitter and occasional frequency hops
    do_reset(3);
    drive_edge(7);
    base = $urandom_range(2, 300);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) base = $urandom_range(2, 300);
      drive_edge(base + $urandom_range(0, 3));
    end
    tick(10);
    compare("rand");
    check("rand_silent", silent, 0);

    // Reset mid-period: next edge only arms
    drive_edge(40);
    drive_edge(40);
    tick(15);
    compare("pre6");
    do_reset(1);
    check_reset("t6_rst");
    drive_edge(50);
    tick(30);
    check("t6_noreport", obs_q.size(), 0);
    check("t6_silent", silent, 0);
    drive_edge(50);
    tick(10);
    compare("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
